cache_stats_mmio: RTL and testbench

Memory-mapped readout stage downstream of `cache_stats`. It consumes the six live 32-bit cache counters and exposes them to software through a 256-byte load/store window on the CPU data port. Software controls it with two commands. Snapshot freezes a consistent copy of all counters. Clear rebases the counters so later snapshots report deltas. Because `cache_stats` has no reset, the baseline mechanism is the only way software gets zero-relative counts.

---
 rtl/cache_stats_pkg.sv | 54 +++++
 rtl/stats_snapshot_bank.sv | 83 ++++++++
 rtl/cache_stats_mmio.sv | 155 +++++++++++++++
 tb/tb_cache_stats_mmio.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// ---------------------------------------------------------------------------
// cache_stats_pkg
//
// Shared definitions for the cache statistics MMIO readout slice:
//   - default window base address
//   - register offsets inside the 256-byte window
//   - CTRL register bit positions
//   - readout FSM state type
//   - small decode helpers used by the top level
// ---------------------------------------------------------------------------
package cache_stats_pkg;

    // Default window base; the low byte is the in-window offset and must be 0.
    localparam logic [31:0] STAT_BASE_ADDR = 32'hFFFF_FF00;

    // Number of counters mirrored by the snapshot bank.
    localparam int NUM_STATS = 6;

    // Register offsets inside the window.
    localparam logic [7:0] STAT_OFF_INSTR_ACCESS = 8'h00;
    localparam logic [7:0] STAT_OFF_DATA_ACCESS  = 8'h04;
    localparam logic [7:0] STAT_OFF_L1_ACCESS    = 8'h08;
    localparam logic [7:0] STAT_OFF_INSTR_CYCLES = 8'h0C;
    localparam logic [7:0] STAT_OFF_DATA_CYCLES  = 8'h10;
    localparam logic [7:0] STAT_OFF_L1_CYCLES    = 8'h14;
    localparam logic [7:0] STAT_OFF_CTRL         = 8'h18;
    localparam logic [7:0] STAT_OFF_SEQ          = 8'h1C;

    // CTRL register bit positions.
    localparam int CTRL_SNAP_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;

    // Readout FSM: a request is taken in IDLE and answered from RESP.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } mmio_state_t;

    // True when the offset is word aligned.
    function automatic logic is_word_aligned(input logic [7:0] off);
        return (off[1:0] == 2'b00);
    endfunction

    // True when the offset addresses one of the six snapshot registers.
    function automatic logic is_snapshot_offset(input logic [7:0] off);
        return is_word_aligned(off) && (off <= STAT_OFF_L1_CYCLES);
    endfunction

    // Snapshot index for an in-range snapshot offset (offset / 4).
    function automatic logic [2:0] snapshot_index(input logic [7:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/stats_snapshot_bank.sv
// ---------------------------------------------------------------------------
// stats_snapshot_bank
//
// Holds one baseline and one snapshot register per live counter, plus the
// subtractors that turn live values into baseline-relative deltas.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   snap                load every snapshot with (live - baseline)
//   clr                 load every baseline with live, zero every snapshot;
//                       takes priority over snap
//   live_*              six live 32-bit counters
//   rd_idx              snapshot select (0..5); other values read as 0
//   rd_data             selected snapshot, combinational
// ---------------------------------------------------------------------------
module stats_snapshot_bank
    import cache_stats_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snap,
    input  logic        clr,
    input  logic [31:0] live_instr_access,
    input  logic [31:0] live_data_access,
    input  logic [31:0] live_l1_access,
    input  logic [31:0] live_instr_cycles,
    input  logic [31:0] live_data_cycles,
    input  logic [31:0] live_l1_cycles,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [31:0] live     [NUM_STATS];
    logic [31:0] baseline [NUM_STATS];
    logic [31:0] snapshot [NUM_STATS];
    logic [31:0] delta    [NUM_STATS];

    // Gather the live counters in register-map order so the loops below
    // line up index-for-index with the snapshot offsets.
    assign live[0] = live_instr_access;
    assign live[1] = live_data_access;
    assign live[2] = live_l1_access;
    assign live[3] = live_instr_cycles;
    assign live[4] = live_data_cycles;
    assign live[5] = live_l1_cycles;

    // Modulo-2^32 difference; a live value below its baseline simply wraps,
    // which is the right answer for a free-running counter that overflowed.
    always_comb begin
        for (int i = 0; i < NUM_STATS; i++) begin
            delta[i] = live[i] - baseline[i];
        end
    end

    // Baselines and snapshots all update on the same edge so software always
    // sees a mutually consistent set of six values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                baseline[i] <= '0;
                snapshot[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                baseline[i] <= live[i];
                snapshot[i] <= '0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                snapshot[i] <= delta[i];
            end
        end
    end

    // Read-out mux; indices 6 and 7 have no register behind them.
    always_comb begin
        rd_data = '0;
        if (rd_idx < 3'(NUM_STATS)) begin
            rd_data = snapshot[rd_idx];
        end
    end

endmodule

// File: rtl/cache_stats_mmio.sv
// ---------------------------------------------------------------------------
// cache_stats_mmio
//
// Memory-mapped readout of the six cache_stats counters through a 256-byte
// window on the CPU data port. Software writes CTRL to snapshot (bit0) or
// rebase/clear (bit1) the counters and reads the frozen values back.
//
// Parameters:
//   BASE_ADDR           window base, low byte must be zero
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   num_*/ *_cycles     live counters from cache_stats
//   mem_address         CPU data address
//   mem_read/mem_write  request strobes, held until mem_resp
//   mem_wdata           store data
//   mem_byte_enable     store byte mask (only lane 0 matters for CTRL)
//   mmio_sel            combinational window hit, used by the upstream mux
//   mem_rdata           registered load data, held until the next request
//   mem_resp            one-cycle completion pulse
//
// Map: 0x00-0x14 snapshots, 0x18 CTRL (write-only), 0x1C SEQ (read-only).
// ---------------------------------------------------------------------------
module cache_stats_mmio
    import cache_stats_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = STAT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] num_instr_access,
    input  logic [31:0] num_data_access,
    input  logic [31:0] num_l1_access,
    input  logic [31:0] instr_cycles,
    input  logic [31:0] data_cycles,
    input  logic [31:0] l1_cycles,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mmio_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_resp
);

    mmio_state_t state;
    mmio_state_t state_next;

    logic [7:0]  offset;
    logic        request;
    logic        accept;
    logic        ctrl_write;
    logic        snap_strobe;
    logic        clr_strobe;
    logic [31:0] seq_count;
    logic [31:0] bank_rd_data;
    logic [31:0] read_value;
    logic        unused_bits;

    // Bits that have no meaning in this block: only byte lane 0 gates CTRL
    // and only the two low data bits are command bits.
    assign unused_bits = ^{mem_byte_enable[3:1], mem_wdata[31:2]};

    assign mmio_sel = (mem_address[31:8] == BASE_ADDR[31:8]);
    assign offset   = mem_address[7:0];
    assign request  = mmio_sel & (mem_read | mem_write);
    assign accept   = (state == IDLE) & request;

    // A CTRL store only counts when it is accepted, aligned and carries lane 0.
    // mem_write wins over mem_read when both are asserted.
    assign ctrl_write = accept & mem_write & is_word_aligned(offset)
                      & (offset == STAT_OFF_CTRL) & mem_byte_enable[0];

    // CLR already zeroes the snapshots, so a simultaneous SNAP is dropped
    // and the sequence counter only steps once.
    assign clr_strobe  = ctrl_write & mem_wdata[CTRL_CLR_BIT];
    assign snap_strobe = ctrl_write & mem_wdata[CTRL_SNAP_BIT] & ~mem_wdata[CTRL_CLR_BIT];

    stats_snapshot_bank u_bank (
        .clk               (clk),
        .rst_n             (rst_n),
        .snap              (snap_strobe),
        .clr               (clr_strobe),
        .live_instr_access (num_instr_access),
        .live_data_access  (num_data_access),
        .live_l1_access    (num_l1_access),
        .live_instr_cycles (instr_cycles),
        .live_data_cycles  (data_cycles),
        .live_l1_cycles    (l1_cycles),
        .rd_idx            (snapshot_index(offset)),
        .rd_data           (bank_rd_data)
    );

    // SEQ counts every command that actually changed the snapshots and
    // wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_count <= '0;
        end else if (snap_strobe | clr_strobe) begin
            seq_count <= seq_count + 32'd1;
        end
    end

    // Load-data decode; CTRL, unmapped and misaligned offsets read as zero.
    always_comb begin
        read_value = '0;
        if (is_snapshot_offset(offset)) begin
            read_value = bank_rd_data;
        end else if (offset == STAT_OFF_SEQ) begin
            read_value = seq_count;
        end
    end

    // Load data is captured on the accepting edge and then held, so it stays
    // stable while the requester samples it alongside mem_resp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rdata <= '0;
        end else if (accept) begin
            mem_rdata <= mem_write ? 32'd0 : read_value;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and response. RESP always lasts exactly one cycle and
    // never accepts, which paces back-to-back requests at one per two cycles.
    always_comb begin
        state_next = state;
        mem_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                mem_resp   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_stats_mmio.sv
// ---------------------------------------------------------------------------
// tb_cache_stats_mmio
//
// Self-checking bench for cache_stats_mmio: a directed vector table, a few
// multi-cycle sequences (held read data, back-to-back pacing, reset during
// a response) and a randomized phase checked against a register-level model.
// ---------------------------------------------------------------------------
module tb_cache_stats_mmio;

    localparam logic [31:0] WIN = 32'hFFFF_FF00;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [5:0][31:0]  live;
    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_byte_enable;
    logic              mmio_sel;
    logic [31:0]       mem_rdata;
    logic              mem_resp;

    int checks = 0;
    int errors = 0;

    // Reference model state: what software should see, by register.
    logic [31:0] mBase [6];
    logic [31:0] mSnap [6];
    logic [31:0] mSeq;

    typedef struct {
        logic [31:0]      addr;
        logic             rd;
        logic             wr;
        logic [31:0]      wd;
        logic [3:0]       be;
        logic [5:0][31:0] lv;
        logic             expSel;
        logic             expResp;
        logic [31:0]      expRdata;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cache_stats_mmio #(.BASE_ADDR(32'hFFFF_FF00)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .num_instr_access (live[0]),
        .num_data_access  (live[1]),
        .num_l1_access    (live[2]),
        .instr_cycles     (live[3]),
        .data_cycles      (live[4]),
        .l1_cycles        (live[5]),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_wdata        (mem_wdata),
        .mem_byte_enable  (mem_byte_enable),
        .mmio_sel         (mmio_sel),
        .mem_rdata        (mem_rdata),
        .mem_resp         (mem_resp)
    );

    function automatic logic [5:0][31:0] mkLive(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] c, input logic [31:0] d,
                                                input logic [31:0] e, input logic [31:0] f);
        logic [5:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    function automatic void addVec(input logic [31:0] addr, input logic rd, input logic wr,
                                   input logic [31:0] wd, input logic [3:0] be,
                                   input logic [5:0][31:0] lv, input logic expSel,
                                   input logic expResp, input logic [31:0] expRdata);
        vec_t v;
        v.addr = addr; v.rd = rd; v.wr = wr; v.wd = wd; v.be = be; v.lv = lv;
        v.expSel = expSel; v.expResp = expResp; v.expRdata = expRdata;
        vecs.push_back(v);
    endfunction

    function automatic void addRead(input logic [7:0] off, input logic [5:0][31:0] lv,
                                    input logic [31:0] exp);
        addVec(WIN | {24'd0, off}, 1'b1, 1'b0, 32'd0, 4'hF, lv, 1'b1, 1'b1, exp);
    endfunction

    function automatic void addWrite(input logic [7:0] off, input logic [31:0] wd,
                                     input logic [3:0] be, input logic [5:0][31:0] lv);
        addVec(WIN | {24'd0, off}, 1'b0, 1'b1, wd, be, lv, 1'b1, 1'b1, 32'd0);
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 6; i++) begin
            mBase[i] = '0;
            mSnap[i] = '0;
        end
        mSeq = '0;
    endfunction

    // Register-level behaviour of one accepted access, straight from the map.
    function automatic void modelAccess(input logic [31:0] addr, input logic rd, input logic wr,
                                        input logic [31:0] wd, input logic [3:0] be,
                                        input logic [5:0][31:0] lv,
                                        output logic expResp, output logic [31:0] expRdata);
        int off;
        expResp  = 1'b0;
        expRdata = 32'd0;
        if (addr[31:8] != WIN[31:8] || !(rd || wr)) return;
        expResp = 1'b1;
        off = int'(addr[7:0]);
        if (wr) begin
            if (addr[1:0] == 2'b00 && off == 24 && be[0]) begin
                if (wd[1]) begin
                    for (int i = 0; i < 6; i++) begin
                        mBase[i] = lv[i];
                        mSnap[i] = 32'd0;
                    end
                    mSeq = mSeq + 1;
                end else if (wd[0]) begin
                    for (int i = 0; i < 6; i++) mSnap[i] = lv[i] - mBase[i];
                    mSeq = mSeq + 1;
                end
            end
        end else if (addr[1:0] == 2'b00) begin
            if (off < 24) expRdata = mSnap[off / 4];
            else if (off == 28) expRdata = mSeq;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One complete bus access: drive after a falling edge, sample mem_resp and
    // mem_rdata 1 time unit after the accepting edge, drop the request, then
    // sample mem_resp once more after the following edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic [5:0][31:0] lv,
                                 output logic gotSel, output logic gotResp,
                                 output logic gotRespAfter, output logic [31:0] gotRdata,
                                 output logic mResp, output logic [31:0] mRdata);
        @(negedge clk);
        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        live            = lv;
        #1;
        gotSel = mmio_sel;
        modelAccess(addr, rd, wr, wd, be, lv, mResp, mRdata);
        @(posedge clk);
        #1;
        gotResp   = mem_resp;
        gotRdata  = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        gotRespAfter = mem_resp;
    endtask

    initial begin
        logic             gSel, gResp, gAfter, mResp;
        logic [31:0]      gRdata, mRdata, heldVal;
        logic [5:0][31:0] la, l7, l8, rl;
        logic [31:0]      rAddr, rWd;
        logic             rRd, rWr;
        logic [3:0]       rBe;

        rst_n           = 1'b0;
        mem_address     = 32'd0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_wdata       = 32'd0;
        mem_byte_enable = 4'd0;
        live            = '0;
        modelReset();

        // ---------------- directed vector table ----------------
        la = mkLive(7, 8, 9, 10, 11, 12);
        for (int o = 0; o < 32; o += 4) addRead(8'(o), la, 32'd0);
        addWrite(8'h18, 32'h1, 4'hF, mkLive(100, 0, 0, 40, 0, 0));
        addRead(8'h00, la, 32'd100);
        addRead(8'h0C, la, 32'd40);
        addRead(8'h1C, la, 32'd1);
        addRead(8'h18, la, 32'd0);
        addWrite(8'h18, 32'h2, 4'hF, mkLive(0, 0, 0, 0, 500, 0));
        addWrite(8'h18, 32'h1, 4'hF, mkLive(0, 0, 0, 0, 530, 0));
        addRead(8'h10, la, 32'd30);
        addRead(8'h1C, la, 32'd3);
        addRead(8'h00, la, 32'd0);
        addWrite(8'h18, 32'h2, 4'hF, mkLive(0, 0, 0, 0, 0, 32'hFFFF_FFF0));
        addWrite(8'h18, 32'h1, 4'hF, mkLive(0, 0, 0, 0, 0, 32'h0000_0010));
        addRead(8'h14, la, 32'h20);
        addWrite(8'h18, 32'h3, 4'hF, mkLive(11, 22, 33, 44, 55, 66));
        l7 = mkLive(111, 122, 133, 144, 155, 166);
        for (int o = 0; o < 24; o += 4) addRead(8'(o), l7, 32'd0);
        addRead(8'h1C, l7, 32'd6);
        addWrite(8'h18, 32'h1, 4'b0010, l7);
        addRead(8'h00, l7, 32'd0);
        addRead(8'h1C, l7, 32'd6);
        addWrite(8'h00, 32'hDEAD_BEEF, 4'hF, l7);
        addRead(8'h00, l7, 32'd0);
        addWrite(8'h18, 32'h1, 4'b0001, l7);
        addRead(8'h08, l7, 32'd100);
        addRead(8'h14, l7, 32'd100);
        addRead(8'h40, l7, 32'd0);
        addRead(8'h1D, l7, 32'd0);
        addRead(8'h09, l7, 32'd0);
        addVec(32'h0000_1000, 1'b1, 1'b0, 32'd0, 4'hF, l7, 1'b0, 1'b0, 32'd0);
        addVec(32'h0000_1018, 1'b0, 1'b1, 32'd3, 4'hF, l7, 1'b0, 1'b0, 32'd0);
        addRead(8'h1C, l7, 32'd7);
        addVec(WIN | 32'h1C, 1'b1, 1'b1, 32'd0, 4'hF, l7, 1'b1, 1'b1, 32'd0);
        addRead(8'h1C, l7, 32'd7);
        l8 = mkLive(211, 222, 233, 244, 255, 266);
        addVec(WIN | 32'h18, 1'b1, 1'b1, 32'd1, 4'hF, l8, 1'b1, 1'b1, 32'd0);
        addRead(8'h04, l8, 32'd200);
        addRead(8'h1C, l8, 32'd8);

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset mem_resp", {31'd0, mem_resp}, 32'd0);
        checkOutput("reset mem_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset mmio_sel low at addr 0", {31'd0, mmio_sel}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].be,
                          vecs[i].lv, gSel, gResp, gAfter, gRdata, mResp, mRdata);
            checkOutput($sformatf("vec%0d mmio_sel", i), {31'd0, gSel}, {31'd0, vecs[i].expSel});
            checkOutput($sformatf("vec%0d mem_resp", i), {31'd0, gResp}, {31'd0, vecs[i].expResp});
            checkOutput($sformatf("vec%0d resp drop", i), {31'd0, gAfter}, 32'd0);
            if (vecs[i].expResp)
                checkOutput($sformatf("vec%0d mem_rdata", i), gRdata, vecs[i].expRdata);
        end

        // ---------------- read data holds after the response ----------------
        applyStimulus(WIN | 32'h14, 1'b1, 1'b0, 32'd0, 4'hF, l8, gSel, gResp, gAfter,
                      gRdata, mResp, mRdata);
        heldVal = mRdata;
        checkOutput("hold first rdata", gRdata, 32'd200);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold rdata after idle", mem_rdata, heldVal);

        // ---------------- back-to-back pacing with request held ----------------
        @(negedge clk);
        mem_address = WIN | 32'h1C;
        mem_read    = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b first resp", {31'd0, mem_resp}, 32'd1);
        checkOutput("b2b first rdata", mem_rdata, mSeq);
        @(posedge clk); #1;
        checkOutput("b2b gap", {31'd0, mem_resp}, 32'd0);
        @(posedge clk); #1;
        checkOutput("b2b second resp", {31'd0, mem_resp}, 32'd1);
        mem_read = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2b idle", {31'd0, mem_resp}, 32'd0);

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 400; n++) begin
            rl = mkLive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            case ($urandom_range(0, 7))
                0:       rAddr = $urandom;
                1, 2:    rAddr = WIN | 32'h18;
                3:       rAddr = WIN | 32'h1C;
                4:       rAddr = WIN | {24'd0, 8'($urandom)};
                default: rAddr = WIN | {27'd0, 5'($urandom)};
            endcase
            rRd = 1'($urandom);
            rWr = 1'($urandom);
            rWd = $urandom;
            rBe = 4'($urandom);
            applyStimulus(rAddr, rRd, rWr, rWd, rBe, rl, gSel, gResp, gAfter, gRdata,
                          mResp, mRdata);
            checkOutput($sformatf("rnd%0d mmio_sel", n), {31'd0, gSel},
                        {31'd0, rAddr[31:8] == WIN[31:8]});
            checkOutput($sformatf("rnd%0d mem_resp", n), {31'd0, gResp}, {31'd0, mResp});
            checkOutput($sformatf("rnd%0d resp drop", n), {31'd0, gAfter}, 32'd0);
            if (mResp) checkOutput($sformatf("rnd%0d mem_rdata", n), gRdata, mRdata);
        end

        // Make sure SEQ is nonzero before the reset test.
        applyStimulus(WIN | 32'h18, 1'b0, 1'b1, 32'd1, 4'hF, l8, gSel, gResp, gAfter,
                      gRdata, mResp, mRdata);

        // ---------------- reset while in RESP ----------------
        @(negedge clk);
        mem_address     = WIN | 32'h1C;
        mem_read        = 1'b1;
        @(posedge clk); #1;
        checkOutput("rstmid resp before reset", {31'd0, mem_resp}, 32'd1);
        checkOutput("rstmid seq read nonzero", {31'd0, mem_rdata != 32'd0}, 32'd1);
        mem_read = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstmid resp dropped", {31'd0, mem_resp}, 32'd0);
        checkOutput("rstmid rdata cleared", mem_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        applyStimulus(WIN | 32'h1C, 1'b1, 1'b0, 32'd0, 4'hF, l8, gSel, gResp, gAfter,
                      gRdata, mResp, mRdata);
        checkOutput("rstmid seq after reset", gRdata, 32'd0);
        checkOutput("rstmid resp after reset", {31'd0, gResp}, 32'd1);
        applyStimulus(WIN | 32'h04, 1'b1, 1'b0, 32'd0, 4'hF, l8, gSel, gResp, gAfter,
                      gRdata, mResp, mRdata);
        checkOutput("rstmid snapshot after reset", gRdata, 32'd0);
        applyStimulus(WIN | 32'h18, 1'b0, 1'b1, 32'd1, 4'hF, l8, gSel, gResp, gAfter,
                      gRdata, mResp, mRdata);
        applyStimulus(WIN | 32'h04, 1'b1, 1'b0, 32'd0, 4'hF, l8, gSel, gResp, gAfter,
                      gRdata, mResp, mRdata);
        checkOutput("rstmid baseline zero after reset", gRdata, 32'd222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
